pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, data-memory
// wait/timeout FSM, EXE operand forwarding selects and a stall-cycle counter.
module pipe_hazard_ctrl (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_use_rs1,
  input  logic        i_id_use_rs2,
  input  logic [4:0]  i_exe_rd,
  input  logic        i_exe_wreg,
  input  logic        i_exe_mem2reg,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_wreg,
  input  logic        i_mem_mem2reg,
  input  logic        i_mem_wmem,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_wreg,
  input  logic        i_exe_branch_taken,
  input  logic        i_dmem_ready,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_idexe_en,
  output logic        o_exemem_en,
  output logic        o_memwb_en,
  output logic        o_ifid_flush,
  output logic        o_idexe_flush,
  output logic [1:0]  o_fwd_a,
  output logic [1:0]  o_fwd_b,
  output logic        o_dmem_err,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] stall_cnt_q;
  logic [4:0]  exe_rs1_q, exe_rs2_q;

  logic mem_req;
  logic load_use;
  logic run_pc_en, run_ifid_en, run_ifid_flush, run_idexe_flush;
  logic mem_stall;
  logic err;

  assign mem_req = i_mem_mem2reg | i_mem_wmem;

  assign load_use = i_exe_wreg & i_exe_mem2reg & (i_exe_rd != 5'd0) &
                    ((i_id_use_rs1 & (i_id_rs1 == i_exe_rd)) |
                     (i_id_use_rs2 & (i_id_rs2 == i_exe_rd)));

  // Hazard decisions when memory is not stalling; a taken branch squashes
  // the dependent ID instruction, so it wins over the load-use interlock.
  always_comb begin
    run_pc_en       = 1'b1;
    run_ifid_en     = 1'b1;
    run_ifid_flush  = 1'b0;
    run_idexe_flush = 1'b0;
    if (i_exe_branch_taken) begin
      run_ifid_flush  = 1'b1;
      run_idexe_flush = 1'b1;
    end else if (load_use) begin
      run_pc_en       = 1'b0;
      run_ifid_en     = 1'b0;
      run_idexe_flush = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_stall = 1'b0;
    err       = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !i_dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = MEMWAIT;
          wcnt_d    = '0;
        end
      end
      MEMWAIT: begin
        if (i_dmem_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == '1) begin
          err     = 1'b1;
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          mem_stall = 1'b1;
          wcnt_d    = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // A memory stall freezes every stage and holds back flushes so the
  // frozen EXE branch is still there when the pipeline resumes.
  assign o_pc_en       = run_pc_en & ~mem_stall;
  assign o_ifid_en     = run_ifid_en & ~mem_stall;
  assign o_idexe_en    = ~mem_stall;
  assign o_exemem_en   = ~mem_stall;
  assign o_memwb_en    = ~mem_stall;
  assign o_ifid_flush  = run_ifid_flush & ~mem_stall;
  assign o_idexe_flush = run_idexe_flush & ~mem_stall;
  assign o_dmem_err    = err;
  assign o_stall_cnt   = stall_cnt_q;

  always_comb begin
    o_fwd_a = 2'b00;
    if (i_mem_wreg && !i_mem_mem2reg && i_mem_rd != 5'd0 && i_mem_rd == exe_rs1_q)
      o_fwd_a = 2'b01;
    else if (i_wb_wreg && i_wb_rd != 5'd0 && i_wb_rd == exe_rs1_q)
      o_fwd_a = 2'b10;
  end

  always_comb begin
    o_fwd_b = 2'b00;
    if (i_mem_wreg && !i_mem_mem2reg && i_mem_rd != 5'd0 && i_mem_rd == exe_rs2_q)
      o_fwd_b = 2'b01;
    else if (i_wb_wreg && i_wb_rd != 5'd0 && i_wb_rd == exe_rs2_q)
      o_fwd_b = 2'b10;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      exe_rs1_q <= '0;
      exe_rs2_q <= '0;
    end else if (o_idexe_flush) begin
      exe_rs1_q <= '0;
      exe_rs2_q <= '0;
    end else if (o_idexe_en) begin
      exe_rs1_q <= i_id_rs1;
      exe_rs2_q <= i_id_rs2;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)
      stall_cnt_q <= '0;
    else if (!o_pc_en && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the RUN hazard and
// forwarding logic, hand sequences for memory wait, timeout and reset.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  id_rs1, id_rs2, exe_rd, mem_rd, wb_rd;
  logic        use1, use2, exe_wreg, exe_m2r, mem_wreg, mem_m2r, mem_wmem;
  logic        wb_wreg, br, ready;
  logic        pc_en, ifid_en, idexe_en, exemem_en, memwb_en;
  logic        ifid_flush, idexe_flush, dmem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_exe_rd(exe_rd), .i_exe_wreg(exe_wreg), .i_exe_mem2reg(exe_m2r),
    .i_mem_rd(mem_rd), .i_mem_wreg(mem_wreg), .i_mem_mem2reg(mem_m2r),
    .i_mem_wmem(mem_wmem),
    .i_wb_rd(wb_rd), .i_wb_wreg(wb_wreg),
    .i_exe_branch_taken(br), .i_dmem_ready(ready),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idexe_en(idexe_en),
    .o_exemem_en(exemem_en), .o_memwb_en(memwb_en),
    .o_ifid_flush(ifid_flush), .o_idexe_flush(idexe_flush),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
    .o_dmem_err(dmem_err), .o_stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] erd;
    logic       ew, em;
    logic [4:0] mrd;
    logic       mw, mm;
    logic [4:0] wrd;
    logic       ww, br;
    logic [4:0] en;     // {pc, ifid, idexe, exemem, memwb}
    logic [1:0] fl;     // {ifid_flush, idexe_flush}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [4:0] enables();
    return {pc_en, ifid_en, idexe_en, exemem_en, memwb_en};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; use1 = 1'b1; use2 = 1'b1;
    exe_rd = '0; exe_wreg = 1'b0; exe_m2r = 1'b0;
    mem_rd = '0; mem_wreg = 1'b0; mem_m2r = 1'b0; mem_wmem = 1'b0;
    wb_rd = '0; wb_wreg = 1'b0; br = 1'b0; ready = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    #2;
    check("reset_stall_cnt", stall_cnt, 16'd0);
    check("reset_err", {15'd0, dmem_err}, 16'd0);
    step();
    resetn = 1'b1;
    #2;
  endtask

  initial begin
    //            rs1   rs2  u1 u2  erd  ew em  mrd  mw mm  wrd  ww br   en        fl     fa     fb
    vecs[0]  = '{5'd7, 5'd3, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{5'd7, 5'd3, 1, 1, 5'd0, 0, 0, 5'd7, 1, 0, 5'd7, 1, 0, 5'b11111, 2'b00, 2'b01, 2'b00};
    vecs[2]  = '{5'd7, 5'd3, 1, 1, 5'd0, 0, 0, 5'd0, 1, 0, 5'd7, 1, 0, 5'b11111, 2'b00, 2'b10, 2'b00};
    vecs[3]  = '{5'd7, 5'd3, 1, 1, 5'd0, 0, 0, 5'd7, 1, 1, 5'd7, 1, 0, 5'b11111, 2'b00, 2'b10, 2'b00};
    vecs[4]  = '{5'd5, 5'd0, 1, 1, 5'd0, 0, 0, 5'd3, 1, 0, 5'd7, 1, 0, 5'b11111, 2'b00, 2'b10, 2'b01};
    vecs[5]  = '{5'd9, 5'd10,1, 1, 5'd0, 0, 0, 5'd5, 0, 0, 5'd5, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{5'd4, 5'd10,1, 1, 5'd10,1, 1, 5'd10,1, 0, 5'd0, 0, 0, 5'b00111, 2'b01, 2'b00, 2'b01};
    vecs[7]  = '{5'd4, 5'd10,1, 0, 5'd10,1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[8]  = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 5'd0, 0, 0, 5'd4, 1, 0, 5'b11111, 2'b00, 2'b10, 2'b00};
    vecs[9]  = '{5'd6, 5'd6, 1, 1, 5'd6, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[10] = '{5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 5'd6, 1, 0, 5'd0, 0, 1, 5'b11111, 2'b11, 2'b01, 2'b01};
    vecs[11] = '{5'd8, 5'd0, 1, 1, 5'd8, 1, 1, 5'd0, 0, 0, 5'd0, 0, 1, 5'b11111, 2'b11, 2'b00, 2'b00};
    vecs[12] = '{5'd8, 5'd0, 1, 1, 5'd8, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 5'b00111, 2'b01, 2'b00, 2'b00};

    do_reset();
    check("reset_enables", {11'd0, enables()}, 16'h001F);

    foreach (vecs[i]) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; use1 = vecs[i].u1; use2 = vecs[i].u2;
      exe_rd = vecs[i].erd; exe_wreg = vecs[i].ew; exe_m2r = vecs[i].em;
      mem_rd = vecs[i].mrd; mem_wreg = vecs[i].mw; mem_m2r = vecs[i].mm; mem_wmem = 1'b0;
      wb_rd = vecs[i].wrd; wb_wreg = vecs[i].ww; br = vecs[i].br; ready = 1'b1;
      #2;
      check($sformatf("vec%0d_en", i), {11'd0, enables()}, {11'd0, vecs[i].en});
      check($sformatf("vec%0d_flush", i), {14'd0, ifid_flush, idexe_flush}, {14'd0, vecs[i].fl});
      check($sformatf("vec%0d_fwd", i), {12'd0, fwd_a, fwd_b}, {12'd0, vecs[i].fa, vecs[i].fb});
      step();
    end
    check("table_stall_cnt", stall_cnt, 16'd2);

    // Single load-use interlock then release.
    do_reset();
    exe_rd = 5'd5; exe_wreg = 1'b1; exe_m2r = 1'b1; id_rs1 = 5'd5; use1 = 1'b1;
    #2;
    check("lu_en", {11'd0, enables()}, 16'h0007);
    check("lu_flush", {14'd0, ifid_flush, idexe_flush}, 16'd1);
    step();
    clear_inputs();
    #2;
    check("lu_after_en", {11'd0, enables()}, 16'h001F);
    check("lu_stall_cnt", stall_cnt, 16'd1);

    // Memory wait of 3 cycles with a branch frozen in EXE.
    do_reset();
    mem_wreg = 1'b1; mem_m2r = 1'b1; ready = 1'b0; br = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #2;
      check($sformatf("mw%0d_en", c), {11'd0, enables()}, 16'h0000);
      check($sformatf("mw%0d_flush", c), {14'd0, ifid_flush, idexe_flush}, 16'd0);
      step();
    end
    ready = 1'b1;
    #2;
    check("mw4_en", {11'd0, enables()}, 16'h001F);
    check("mw4_flush", {14'd0, ifid_flush, idexe_flush}, 16'd3);
    step();
    clear_inputs();
    #2;
    check("mw_stall_cnt", stall_cnt, 16'd3);
    check("mw_after_en", {11'd0, enables()}, 16'h001F);

    // Timeout: ready never arrives.
    do_reset();
    mem_wmem = 1'b1; ready = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      #2;
      if (c < 17)
        check($sformatf("to%0d_en_err", c), {10'd0, enables(), dmem_err}, 16'h0000);
      else
        check("to17_en_err", {10'd0, enables(), dmem_err}, 16'h003F);
      step();
    end
    mem_wmem = 1'b0;
    #2;
    check("to_after_en_err", {10'd0, enables(), dmem_err}, 16'h003E);
    check("to_stall_cnt", stall_cnt, 16'd16);
    step();
    check("to_err_gone", {15'd0, dmem_err}, 16'd0);

    // Reset asserted during the wait.
    do_reset();
    mem_wmem = 1'b1; ready = 1'b0;
    for (int c = 1; c <= 5; c++) step();
    check("rw_pre_stall_cnt", stall_cnt, 16'd5);
    resetn = 1'b0;
    #1;
    check("rw_stall_cnt", stall_cnt, 16'd0);
    check("rw_err", {15'd0, dmem_err}, 16'd0);
    mem_wmem = 1'b0;
    #1;
    check("rw_in_reset_en", {11'd0, enables()}, 16'h001F);
    step();
    resetn = 1'b1;
    #2;
    check("rw_release_en_err", {10'd0, enables(), dmem_err}, 16'h003E);
    step();
    check("rw_final_stall_cnt", stall_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
